conv_frame_ctrl: RTL and testbench
==================================

Name: conv_frame_ctrl

Overview:
Frame sequencer for the 3x3 convolution path. It sits between the pixel source and matrix_3x3 / conv. It accepts a valid/ready pixel stream and drives the line-buffer input with a registered copy of each accepted pixel. It tracks column/row position, flags complete 3x3 windows, and aligns an output-valid mask and coordinates to the conv pipeline latency. It also owns the 27 per-channel coefficient registers and prevents coefficient writes while a frame is in flight.

Parameters:
IMG_W, 480, pixels per line
IMG_H, 272, lines per frame
DW, 16, pixel data width
COE_W, 8, signed coefficient width
CONV_LAT, 3, conv pipeline latency in cycles from lb_valid_in to data_out_en

Ports:
clk  in  1  pixel clock
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; arms a frame from IDLE
abort  in  1  one-cycle pulse; kills the current frame
coe_wr_en  in  1  coefficient write strobe
coe_wr_addr  in  5  index = ch*9 + row*3 + col; ch 0=r, 1=g, 2=b
coe_wr_data  in  COE_W  signed coefficient
coe_bus  out  27*COE_W  packed coefficients; index 0 in the LSBs
coe_wr_err  out  1  pulse: write rejected
pix_valid  in  1  source pixel valid
pix_ready  out  1  controller can accept a pixel
pix_sof  in  1  first pixel of frame, qualified by pix_valid
pix_data  in  DW  pixel
lb_valid_in  out  1  to matrix_3x3 valid_in
lb_din  out  DW  to matrix_3x3 din
win_valid  out  1  current lb pixel completes a 3x3 window
out_valid  out  1  win_valid delayed by CONV_LAT
out_col  out  clog2(IMG_W)  output column, aligned with out_valid
out_row  out  clog2(IMG_H)  output row, aligned with out_valid
busy  out  1  high in RUN or DRAIN
frame_done  out  1  one-cycle pulse at frame end
sync_err  out  1  pulse: unexpected pix_sof

Behaviour:
- FSM states: IDLE, RUN, DRAIN, DONE.
- Reset: state IDLE; col = row = 0. All 1-bit outputs are 0; lb_din, out_col and out_row are 0; the delay line is cleared.
- Coefficient reset values: indices 4, 13 and 22 = 1; all others 0 (identity per channel).
- IDLE -> RUN on start.
- RUN -> DRAIN when the pixel at (IMG_W-1, IMG_H-1) is accepted.
- DRAIN lasts CONV_LAT cycles, then DONE.
- DONE lasts one cycle, then IDLE. frame_done = 1 in DONE.
- abort in any state returns the FSM to IDLE next cycle. It clears counters and the delay line and does not pulse frame_done. Coefficients are kept. abort wins over start.
- pix_ready = 1 only in RUN. Accept = pix_valid & pix_ready.
- On accept: next cycle lb_valid_in = 1 and lb_din = pix_data (latency 1). Otherwise lb_valid_in = 0 and lb_din holds.
- Counters advance only on accept. col wraps at IMG_W-1 to 0 and row increments. Source stalls hold all counters.
- win_valid is registered with lb_valid_in: 1 when the accepted pixel has row >= 2 and col >= 2.
- Window coordinates are (col-2, row-2), i.e. the window's top-left corner.
- The delay line is CONV_LAT stages, shifting every cycle. It carries win_valid, col-2 and row-2, and produces out_valid, out_col and out_row.
- Window count per frame is (IMG_W-2)*(IMG_H-2).
- If pix_sof is accepted while the expected position is not (0,0): pulse sync_err, treat the pixel as (0,0), and continue from there. The delay line is not flushed.
- pix_sof is not required at (0,0); the counter position defines the frame.
- Coefficient writes are accepted in IDLE and DONE only. A write in RUN/DRAIN, or with coe_wr_addr > 26, leaves coe_bus unchanged and pulses coe_wr_err the next cycle.
- An accepted write updates coe_bus the next cycle.
- start while busy is ignored.

Decomposition:
- Shared package conv_pkg: COE_W, NUM_COE = 27, channel base indices (0, 9, 18), FSM state encoding, identity reset constant.
- One sub-module, conv_delay_line: parameterised width/depth shift register with synchronous clear.
- The coefficient register file stays inline.

Test Plan:
Run all scenarios with IMG_W=8, IMG_H=5, CONV_LAT=3.
1. Reset, then check outputs: coe_bus index 4/13/22 = 1 and the rest 0; pix_ready = 0; busy = 0.
2. Write addr 0 = 1 ... addr 8 = 9 and addr 22 = -8 (0xF8) in IDLE -> coe_bus reflects the writes one cycle later. Write addr 27 -> coe_wr_err pulse, coe_bus unchanged.
3. start, then 40 back-to-back pixels 0..39 -> lb_din mirrors with 1-cycle lag.
   - win_valid count = 18; first win_valid on pixel 18 (row 2, col 2).
   - out_valid count = 18, first with out_col = 0 and out_row = 0; last with out_col = 5 and out_row = 2.
   - frame_done 3+1 cycles after the last accept.
4. Random pix_valid gaps at 50% density -> same 18 windows and coordinates as scenario 3; lb_valid_in never high without a prior accept.
5. pix_sof on pixel 13 (row 1, col 5) -> sync_err pulse; that pixel is counted as (0,0); 18 more windows follow before frame_done.
6. abort at pixel 20, then coe write in RUN before the abort -> coe_wr_err. After the abort: IDLE, busy = 0, no frame_done, out_valid low within 1 cycle; a new start runs a clean frame.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 convolution frame controller:
// coefficient layout, identity reset pattern and FSM encoding.
package conv_pkg;

    localparam int unsigned COE_W   = 8;
    localparam int unsigned NUM_COE = 27;

    localparam int unsigned CH_R_BASE = 0;
    localparam int unsigned CH_G_BASE = 9;
    localparam int unsigned CH_B_BASE = 18;

    // Centre tap of each channel is 1, everything else 0: pass-through kernel.
    localparam logic [NUM_COE-1:0] COE_IDENT_MASK =
        (NUM_COE'(1) << (CH_R_BASE + 4)) |
        (NUM_COE'(1) << (CH_G_BASE + 4)) |
        (NUM_COE'(1) << (CH_B_BASE + 4));

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/conv_delay_line.sv
// Fixed-depth shift register with synchronous clear; shifts every cycle.
module conv_delay_line #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the 3x3 conv path: pixel handshake, position tracking,
// window flagging aligned to conv latency, and the coefficient register file.
module conv_frame_ctrl #(
    parameter int unsigned IMG_W    = 480,
    parameter int unsigned IMG_H    = 272,
    parameter int unsigned DW       = 16,
    parameter int unsigned COE_W    = conv_pkg::COE_W,
    parameter int unsigned CONV_LAT = 3
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic                                 coe_wr_en,
    input  logic [4:0]                           coe_wr_addr,
    input  logic [COE_W-1:0]                     coe_wr_data,
    output logic [conv_pkg::NUM_COE*COE_W-1:0]   coe_bus,
    output logic                                 coe_wr_err,
    input  logic                                 pix_valid,
    output logic                                 pix_ready,
    input  logic                                 pix_sof,
    input  logic [DW-1:0]                        pix_data,
    output logic                                 lb_valid_in,
    output logic [DW-1:0]                        lb_din,
    output logic                                 win_valid,
    output logic                                 out_valid,
    output logic [$clog2(IMG_W)-1:0]             out_col,
    output logic [$clog2(IMG_H)-1:0]             out_row,
    output logic                                 busy,
    output logic                                 frame_done,
    output logic                                 sync_err
);

    import conv_pkg::NUM_COE;
    import conv_pkg::COE_IDENT_MASK;
    import conv_pkg::ST_IDLE;
    import conv_pkg::ST_RUN;
    import conv_pkg::ST_DRAIN;
    import conv_pkg::ST_DONE;

    localparam int unsigned CW  = $clog2(IMG_W);
    localparam int unsigned RW  = $clog2(IMG_H);
    localparam int unsigned DLW = 1 + CW + RW;
    localparam int unsigned DCW = $clog2(CONV_LAT + 1);

    logic [1:0]     state, state_nxt;
    logic [CW-1:0]  col, col_nxt, eff_col, win_col;
    logic [RW-1:0]  row, row_nxt, eff_row, win_row;
    logic [DCW-1:0] drain_cnt, drain_cnt_nxt;
    logic           accept, sof_err, last_pix, win_hit, coe_ok;
    logic [DLW-1:0] dl_out;

    assign accept = pix_valid & pix_ready & ~abort;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            col       <= '0;
            row       <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            col       <= col_nxt;
            row       <= row_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    // Next-state, position tracking and resync on an out-of-place pix_sof
    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        col_nxt       = col;
        row_nxt       = row;
        eff_col       = col;
        eff_row       = row;
        sof_err       = 1'b0;

        if (accept && pix_sof && (col != '0 || row != '0)) begin
            sof_err = 1'b1;
            eff_col = '0;
            eff_row = '0;
        end

        last_pix = accept && (eff_col == CW'(IMG_W - 1)) && (eff_row == RW'(IMG_H - 1));
        win_hit  = (eff_row >= RW'(2)) && (eff_col >= CW'(2));

        if (accept) begin
            if (eff_col == CW'(IMG_W - 1)) begin
                col_nxt = '0;
                row_nxt = (eff_row == RW'(IMG_H - 1)) ? '0 : eff_row + RW'(1);
            end else begin
                col_nxt = eff_col + CW'(1);
                row_nxt = eff_row;
            end
        end

        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (last_pix) begin
                    state_nxt     = ST_DRAIN;
                    drain_cnt_nxt = '0;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == DCW'(CONV_LAT - 1)) state_nxt = ST_DONE;
                else                                 drain_cnt_nxt = drain_cnt + DCW'(1);
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase

        if (abort) begin
            state_nxt     = ST_IDLE;
            col_nxt       = '0;
            row_nxt       = '0;
            drain_cnt_nxt = '0;
        end
    end

    // Registered status and line-buffer outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_ready   <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            sync_err    <= 1'b0;
            lb_valid_in <= 1'b0;
            win_valid   <= 1'b0;
            lb_din      <= '0;
            win_col     <= '0;
            win_row     <= '0;
        end else begin
            pix_ready   <= (state_nxt == ST_RUN);
            busy        <= (state_nxt == ST_RUN) || (state_nxt == ST_DRAIN);
            frame_done  <= (state_nxt == ST_DONE);
            sync_err    <= sof_err;
            lb_valid_in <= accept;
            win_valid   <= accept && win_hit;
            if (accept) begin
                lb_din  <= pix_data;
                win_col <= eff_col - CW'(2);
                win_row <= eff_row - RW'(2);
            end
        end
    end

    conv_delay_line #(
        .WIDTH (DLW),
        .DEPTH (CONV_LAT)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (abort),
        .din   ({win_valid, win_col, win_row}),
        .dout  (dl_out)
    );

    assign {out_valid, out_col, out_row} = dl_out;

    // Coefficients are only writable while no frame is in flight
    assign coe_ok = ((state == ST_IDLE) || (state == ST_DONE)) && (coe_wr_addr <= 5'(NUM_COE - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            coe_wr_err <= 1'b0;
            for (int i = 0; i < int'(NUM_COE); i++) begin
                coe_bus[i*COE_W +: COE_W] <= COE_IDENT_MASK[i] ? COE_W'(1) : '0;
            end
        end else begin
            coe_wr_err <= coe_wr_en && !coe_ok;
            if (coe_wr_en && coe_ok) begin
                coe_bus[int'(coe_wr_addr)*COE_W +: COE_W] <= coe_wr_data;
            end
        end
    end

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Directed bench for conv_frame_ctrl on an 8x5 frame with a 3-cycle conv latency.
module tb_conv_frame_ctrl;

    localparam int unsigned IMG_W    = 8;
    localparam int unsigned IMG_H    = 5;
    localparam int unsigned DW       = 16;
    localparam int unsigned COE_W    = 8;
    localparam int unsigned CONV_LAT = 3;
    localparam int unsigned NUM_COE  = 27;

    logic                       clk = 1'b0;
    logic                       rst_n, start, abort, coe_wr_en, pix_valid, pix_sof;
    logic [4:0]                 coe_wr_addr;
    logic [COE_W-1:0]           coe_wr_data;
    logic [NUM_COE*COE_W-1:0]   coe_bus;
    logic                       coe_wr_err, pix_ready, lb_valid_in, win_valid, out_valid;
    logic                       busy, frame_done, sync_err;
    logic [DW-1:0]              pix_data, lb_din;
    logic [2:0]                 out_col, out_row;

    conv_frame_ctrl #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW), .COE_W(COE_W), .CONV_LAT(CONV_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .coe_wr_en(coe_wr_en), .coe_wr_addr(coe_wr_addr), .coe_wr_data(coe_wr_data),
        .coe_bus(coe_bus), .coe_wr_err(coe_wr_err),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_sof(pix_sof), .pix_data(pix_data),
        .lb_valid_in(lb_valid_in), .lb_din(lb_din), .win_valid(win_valid),
        .out_valid(out_valid), .out_col(out_col), .out_row(out_row),
        .busy(busy), .frame_done(frame_done), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [COE_W-1:0] exp_coe [NUM_COE];

    task automatic check_coe(input string tag);
        for (int i = 0; i < int'(NUM_COE); i++) begin
            check_eq($sformatf("%s_coe%0d", tag, i), 32'(coe_bus[i*COE_W +: COE_W]), 32'(exp_coe[i]));
        end
    endtask

    // Stream monitor: lb mirroring, delay alignment, window order, event counts
    bit          mon_en = 1'b0;
    bit          prev_acc = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [2:0]  hist = '0;
    int          cyc = 0, last_acc_cyc = 0, fd_cyc = 0;
    int          win_cnt = 0, out_cnt = 0, sync_cnt = 0, fd_cnt = 0;
    int          last_oc = -1, last_or = -1;
    logic [DW-1:0] first_win_data = '0;

    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            check_eq("lb_valid_in", 32'(lb_valid_in), 32'(prev_acc));
            if (prev_acc) check_eq("lb_din", 32'(lb_din), 32'(prev_data));
            check_eq("out_align", 32'(out_valid), 32'(hist[2]));
            if (win_valid) begin
                if (win_cnt == 0) first_win_data = lb_din;
                win_cnt++;
            end
            if (out_valid) begin
                check_eq("out_col", 32'(out_col), 32'(out_cnt % int'(IMG_W - 2)));
                check_eq("out_row", 32'(out_row), 32'(out_cnt / int'(IMG_W - 2)));
                last_oc = int'(out_col);
                last_or = int'(out_row);
                out_cnt++;
            end
            if (sync_err) sync_cnt++;
            if (frame_done) begin
                fd_cnt++;
                fd_cyc = cyc;
            end
            prev_acc  = pix_valid && pix_ready && !abort;
            prev_data = pix_data;
            if (prev_acc) last_acc_cyc = cyc;
            hist = abort ? 3'b000 : {hist[1:0], win_valid};
        end
    end

    task automatic clear_stats();
        win_cnt = 0; out_cnt = 0; sync_cnt = 0; fd_cnt = 0;
        last_oc = -1; last_or = -1; first_win_data = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
    endtask

    task automatic coe_write(input logic [4:0] a, input logic [COE_W-1:0] d);
        coe_wr_en = 1'b1; coe_wr_addr = a; coe_wr_data = d;
        @(posedge clk); #1 coe_wr_en = 1'b0;
    endtask

    task automatic send_pix(input logic [DW-1:0] d, input bit sof, input bit gaps);
        bit done = 1'b0;
        int guard = 0;
        while (!done && guard < 100) begin
            pix_valid = gaps ? 1'($urandom_range(1, 0)) : 1'b1;
            pix_data  = d;
            pix_sof   = sof;
            done      = pix_valid && pix_ready;
            @(posedge clk); #1;
            guard++;
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        check_eq("pix_accepted", 32'(done), 32'd1);
    endtask

    task automatic wait_frame_done();
        int g = 0;
        while (fd_cnt == 0 && g < 30) begin
            @(negedge clk);
            g++;
        end
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic check_frame(input string tag, input int first_pix, input int sof_cnt);
        check_eq({tag, "_win_cnt"},   32'(win_cnt), 32'd18);
        check_eq({tag, "_out_cnt"},   32'(out_cnt), 32'd18);
        check_eq({tag, "_first_win"}, 32'(first_win_data), 32'(first_pix));
        check_eq({tag, "_last_col"},  32'(last_oc), 32'd5);
        check_eq({tag, "_last_row"},  32'(last_or), 32'd2);
        check_eq({tag, "_sync_cnt"},  32'(sync_cnt), 32'(sof_cnt));
        check_eq({tag, "_fd_cnt"},    32'(fd_cnt), 32'd1);
        check_eq({tag, "_fd_lat"},    32'(fd_cyc - last_acc_cyc), 32'd4);
        check_eq({tag, "_busy_end"},  32'(busy), 32'd0);
        check_eq({tag, "_rdy_end"},   32'(pix_ready), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        coe_wr_en = 1'b0; coe_wr_addr = '0; coe_wr_data = '0;
        pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        for (int i = 0; i < int'(NUM_COE); i++) begin
            exp_coe[i] = (i == 4 || i == 13 || i == 22) ? 8'd1 : 8'd0;
        end
        check_coe("rst");
        check_eq("rst_pix_ready", 32'(pix_ready), 32'd0);
        check_eq("rst_busy",      32'(busy), 32'd0);
        check_eq("rst_lb_valid",  32'(lb_valid_in), 32'd0);
        check_eq("rst_lb_din",    32'(lb_din), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_col",   32'(out_col), 32'd0);
        check_eq("rst_out_row",   32'(out_row), 32'd0);
        check_eq("rst_frame_done",32'(frame_done), 32'd0);
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Coefficient writes in IDLE, then an out-of-range address
        for (int i = 0; i < 9; i++) begin
            coe_write(5'(i), 8'(i + 1));
            exp_coe[i] = 8'(i + 1);
            check_eq($sformatf("wr_coe%0d", i), 32'(coe_bus[i*COE_W +: COE_W]), 32'(i + 1));
            check_eq("wr_err_ok", 32'(coe_wr_err), 32'd0);
        end
        coe_write(5'd22, 8'hF8);
        exp_coe[22] = 8'hF8;
        check_coe("wr");
        coe_write(5'd27, 8'h55);
        check_eq("wr_err_addr27", 32'(coe_wr_err), 32'd1);
        check_coe("wr27");
        @(posedge clk); #1;
        check_eq("wr_err_pulse", 32'(coe_wr_err), 32'd0);

        // Back-to-back frame
        clear_stats();
        pulse_start();
        check_eq("s3_busy", 32'(busy), 32'd1);
        check_eq("s3_ready", 32'(pix_ready), 32'd1);
        for (int i = 0; i < 40; i++) send_pix(DW'(i), 1'b0, 1'b0);
        wait_frame_done();
        check_frame("s3", 18, 0);

        // Source gaps
        clear_stats();
        pulse_start();
        for (int i = 0; i < 40; i++) send_pix(DW'(100 + i), 1'b0, 1'b1);
        wait_frame_done();
        check_frame("s4", 118, 0);

        // Mid-frame pix_sof resynchronises to (0,0)
        clear_stats();
        pulse_start();
        for (int i = 0; i < 53; i++) send_pix(DW'(i), (i == 13), 1'b0);
        wait_frame_done();
        check_frame("s5", 31, 1);

        // Write during RUN is rejected, then abort mid-frame
        clear_stats();
        pulse_start();
        coe_write(5'd0, 8'h77);
        check_eq("s6_wr_err", 32'(coe_wr_err), 32'd1);
        check_coe("s6_run");
        for (int i = 0; i < 20; i++) send_pix(DW'(i), 1'b0, 1'b0);
        pulse_abort();
        check_eq("s6_busy",      32'(busy), 32'd0);
        check_eq("s6_ready",     32'(pix_ready), 32'd0);
        check_eq("s6_out_valid", 32'(out_valid), 32'd0);
        repeat (8) @(posedge clk);
        #1;
        check_eq("s6_no_done",  32'(fd_cnt), 32'd0);
        check_eq("s6_win_cnt",  32'(win_cnt), 32'd2);
        check_eq("s6_out_cnt",  32'(out_cnt), 32'd0);
        check_coe("s6_kept");

        clear_stats();
        pulse_start();
        for (int i = 0; i < 40; i++) send_pix(DW'(200 + i), 1'b0, 1'b0);
        wait_frame_done();
        check_frame("s6b", 218, 0);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
